imem_load_ctrl: RTL

- Owns the single port of the RV32I instruction memory and shares it between two requesters: a program loader (word stream) and the pipeline fetch stage.
- After reset it runs a boot-load sequence, holds fetch stalled until the program image is written, then grants the port to fetch.
- A runtime reload request can later pull the memory back into load mode.
- It also tracks the loaded instruction count and flags illegal fetches.

---
 rtl/imem_load_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/imem_load_ctrl.sv
// Instruction-memory port arbiter: boot/reload image loader vs. fetch stage.
// Latency: fetch data is combinational from mem_rdata; state, counts and fault are registered.
// Backpressure: ld_ready is high only while loading; fetch_stall holds the PC outside RUN.
module imem_load_ctrl #(
    parameter int          DEPTH     = 1024,
    parameter int          AW        = 10,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          reload,
    input  logic [31:0]   fetch_addr,
    output logic [31:0]   fetch_instr,
    output logic          fetch_stall,
    output logic          fetch_fault,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [AW:0]   instr_count,
    output logic          load_done
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [AW:0] WP_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] WP_ONE  = (AW+1)'(1);

    state_t      state_q, state_d;
    logic [AW:0] wp_q, wp_d;
    logic [AW:0] cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic        fetch_legal;

    // Word-aligned and inside the loaded image; any upper address bit set is out of range.
    assign fetch_legal = (fetch_addr[1:0] == 2'b00) && (fetch_addr[31:2] < 30'(cnt_q));

    // Next-state: load progression, fault capture in RUN, and reload teardown.
    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        case (state_q)
            S_LOAD: begin
                if (ld_valid) begin
                    wp_d = wp_q + WP_ONE;
                    // The last physical word ends the load even without ld_last.
                    if (ld_last || (wp_q == WP_LAST)) begin
                        state_d = S_RUN;
                        cnt_d   = wp_q + WP_ONE;
                    end
                end
            end
            S_RUN: begin
                if (!fetch_legal) begin
                    fault_d = 1'b1;
                end
                // Teardown happens on the way into DRAIN so the old image is gone immediately.
                if (reload) begin
                    state_d = S_DRAIN;
                    wp_d    = '0;
                    cnt_d   = '0;
                    fault_d = 1'b0;
                end
            end
            S_DRAIN: begin
                state_d = S_LOAD;
                wp_d    = '0;
                cnt_d   = '0;
                fault_d = 1'b0;
            end
            default: begin
                state_d = S_LOAD;
                wp_d    = '0;
                cnt_d   = '0;
                fault_d = 1'b0;
            end
        endcase
    end

    // State registers; rst overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            wp_q    <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Port ownership: loader in LOAD, fetch in RUN, nobody in DRAIN or while in reset.
    always_comb begin
        ld_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = wp_q[AW-1:0];
        mem_wdata   = ld_data;
        fetch_stall = 1'b1;
        fetch_instr = NOP_INSTR;
        if (!rst) begin
            case (state_q)
                S_LOAD: begin
                    ld_ready = 1'b1;
                    mem_we   = ld_valid;
                end
                S_RUN: begin
                    mem_addr    = fetch_addr[AW+1:2];
                    fetch_stall = 1'b0;
                    fetch_instr = fetch_legal ? mem_rdata : NOP_INSTR;
                end
                default: begin
                    ld_ready = 1'b0;
                end
            endcase
        end
    end

    assign fetch_fault = fault_q;
    assign instr_count = cnt_q;
    assign load_done   = (state_q == S_RUN);

endmodule
